// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, the transmit FSM state type and the
// byte-wise reflected CRC-32 step used by crc32_d8.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP    = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IP    = 8'h04;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;

    localparam int PREAMBLE_LEN  = 8;   // 7x 0x55 plus SFD
    localparam int ARP_HDR_LEN   = 42;  // Ethernet header + ARP payload
    localparam int MIN_FRAME_LEN = 60;
    localparam int PAD_LEN       = MIN_FRAME_LEN - ARP_HDR_LEN;
    localparam int FCS_LEN       = 4;
    localparam int IFG_LEN       = 12;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;  // CRC32_POLY bit-reversed
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAME,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } arp_tx_state_t;

    // One byte of reflected CRC-32, data bits consumed LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// 8-bit-per-cycle Ethernet CRC-32 register. Output is the raw (uncomplemented)
// register; the user complements it for the FCS. Shared with the receive side.
module crc32_d8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    import eth_pkg::*;

    logic [31:0] crc_q, crc_d;

    // Next CRC value: clear wins over enable
    always_comb begin
        crc_d = crc_q;
        if (clear)       crc_d = CRC32_INIT;
        else if (enable) crc_d = crc32_next(crc_q, data);
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (rst) crc_q <= CRC32_INIT;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/arp_tx.sv
// ARP reply transmitter onto GMII. One registered output stage, so a request
// accepted at edge N shows its first preamble byte after edge N+1.
// Optional build macro: ARP_TX_GRATUITOUS_EN adds garp_req (gratuitous ARP
// broadcast) with its own single-entry pending slot.
//
// state       | meaning
// ST_IDLE     | waiting for a request (live or pending)
// ST_PREAMBLE | 7x 0x55 then SFD
// ST_FRAME    | 42 header/ARP bytes, CRC accumulating
// ST_PAD      | 18 zero pad bytes, CRC accumulating
// ST_FCS      | 4 FCS bytes, LSB first
// ST_IFG      | 12 idle cycles; a pending request starts on the last one
module arp_tx (
    input  logic        aclk,
    input  logic        areset,
`ifdef ARP_TX_GRATUITOUS_EN
    input  logic        garp_req,
`endif
    input  logic        arp_data_valid,
    input  logic [47:0] rq_mac_addr,
    input  logic [31:0] rq_ip_addr,
    input  logic [47:0] mac_s_addr,
    input  logic [31:0] ip_s_addr,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        tx_done
);
    import eth_pkg::*;

    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] HDR_LAST = 6'(ARP_HDR_LEN - 1);
    localparam logic [5:0] PAD_LAST = 6'(PAD_LEN - 1);
    localparam logic [5:0] FCS_LAST = 6'(FCS_LEN - 1);
    localparam logic [5:0] IFG_LAST = 6'(IFG_LEN - 1);

    arp_tx_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;

    logic          pend_rp_q, pend_rp_d;
    logic [47:0]   pend_mac_q, pend_mac_d;
    logic [31:0]   pend_ip_q, pend_ip_d;

    logic          is_garp_q, is_garp_d;
    logic [47:0]   peer_mac_q, peer_mac_d;
    logic [31:0]   peer_ip_q, peer_ip_d;
    logic [47:0]   loc_mac_q, loc_mac_d;
    logic [31:0]   loc_ip_q, loc_ip_d;

    logic [7:0]    txd_q, txd_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_done_q, tx_done_d;
    logic          busy_q, busy_d;

    logic          can_start, start, start_garp;
    logic [47:0]   start_mac;
    logic [31:0]   start_ip;
    logic          garp_live, garp_pend;

    logic          crc_clear, crc_en;
    logic [31:0]   crc_val, fcs;
    logic [335:0]  hdr;
    logic [5:0]    hdr_idx;
    logic [7:0]    hdr_byte;

`ifdef ARP_TX_GRATUITOUS_EN
    logic pend_garp_q, pend_garp_d;
    assign garp_live = garp_req;
    assign garp_pend = pend_garp_q;
`else
    assign garp_live = 1'b0;
    assign garp_pend = 1'b0;
`endif

    // Start arbitration (pending reply > pending garp > live reply > live garp),
    // pending-slot capture and frame field latching
    always_comb begin
        can_start  = (state_q == ST_IDLE) || ((state_q == ST_IFG) && (cnt_q == IFG_LAST));
        start      = 1'b0;
        start_garp = 1'b0;
        start_mac  = rq_mac_addr;
        start_ip   = rq_ip_addr;
        pend_rp_d  = pend_rp_q;
        pend_mac_d = pend_mac_q;
        pend_ip_d  = pend_ip_q;
        if (can_start) begin
            if (pend_rp_q) begin
                start     = 1'b1;
                start_mac = pend_mac_q;
                start_ip  = pend_ip_q;
                pend_rp_d = 1'b0;
            end else if (garp_pend) begin
                start      = 1'b1;
                start_garp = 1'b1;
            end else if (arp_data_valid) begin
                start = 1'b1;
            end else if (garp_live) begin
                start      = 1'b1;
                start_garp = 1'b1;
            end
        end
        // A reply not started right now goes to the slot only if it was empty
        if (arp_data_valid && !pend_rp_q && !(start && !start_garp)) begin
            pend_rp_d  = 1'b1;
            pend_mac_d = rq_mac_addr;
            pend_ip_d  = rq_ip_addr;
        end
`ifdef ARP_TX_GRATUITOUS_EN
        pend_garp_d = pend_garp_q;
        if (start_garp) pend_garp_d = 1'b0;
        if (garp_live && !start_garp && !pend_garp_q) pend_garp_d = 1'b1;
`endif
        is_garp_d  = is_garp_q;
        peer_mac_d = peer_mac_q;
        peer_ip_d  = peer_ip_q;
        loc_mac_d  = loc_mac_q;
        loc_ip_d   = loc_ip_q;
        if (start) begin
            is_garp_d  = start_garp;
            peer_mac_d = start_mac;
            peer_ip_d  = start_ip;
            loc_mac_d  = mac_s_addr;
            loc_ip_d   = ip_s_addr;
        end
    end

    // Header image, first transmitted byte in the top bits
    always_comb begin
        hdr = {is_garp_q ? 48'hFFFF_FFFF_FFFF : peer_mac_q,
               loc_mac_q, ETH_TYPE_ARP, ARP_HTYPE_ETH, ETH_TYPE_IP,
               ARP_HLEN_ETH, ARP_PLEN_IP,
               is_garp_q ? ARP_OPER_REQ : ARP_OPER_REPLY,
               loc_mac_q, loc_ip_q,
               is_garp_q ? 48'h0 : peer_mac_q,
               is_garp_q ? loc_ip_q : peer_ip_q};
        hdr_idx  = HDR_LAST - cnt_q;
        hdr_byte = hdr[{hdr_idx, 3'b000} +: 8];
        fcs      = ~crc_val;
    end

    // Next state, byte counter and next registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 6'd1;
        txd_d     = 8'h00;
        tx_en_d   = 1'b0;
        tx_done_d = 1'b0;
        crc_en    = 1'b0;
        crc_clear = start;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 6'd0;
                if (start) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_FRAME;
                    cnt_d   = 6'd0;
                end
            end
            ST_FRAME: begin
                tx_en_d = 1'b1;
                txd_d   = hdr_byte;
                crc_en  = 1'b1;
                if (cnt_q == HDR_LAST) begin
                    state_d = ST_PAD;
                    cnt_d   = 6'd0;
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                if (cnt_q == PAD_LAST) begin
                    state_d = ST_FCS;
                    cnt_d   = 6'd0;
                end
            end
            ST_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == FCS_LAST) begin
                    tx_done_d = 1'b1;
                    state_d   = ST_IFG;
                    cnt_d     = 6'd0;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = start ? ST_PREAMBLE : ST_IDLE;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    crc32_d8 u_crc (
        .clk    (aclk),
        .rst    (areset),
        .clear  (crc_clear),
        .enable (crc_en),
        .data   (txd_d),
        .crc    (crc_val)
    );

    // State, slots, latched fields and output registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            pend_rp_q  <= 1'b0;
            pend_mac_q <= 48'h0;
            pend_ip_q  <= 32'h0;
            is_garp_q  <= 1'b0;
            peer_mac_q <= 48'h0;
            peer_ip_q  <= 32'h0;
            loc_mac_q  <= 48'h0;
            loc_ip_q   <= 32'h0;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_rp_q  <= pend_rp_d;
            pend_mac_q <= pend_mac_d;
            pend_ip_q  <= pend_ip_d;
            is_garp_q  <= is_garp_d;
            peer_mac_q <= peer_mac_d;
            peer_ip_q  <= peer_ip_d;
            loc_mac_q  <= loc_mac_d;
            loc_ip_q   <= loc_ip_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef ARP_TX_GRATUITOUS_EN
    // Gratuitous-ARP pending slot
    always_ff @(posedge aclk) begin
        if (areset) pend_garp_q <= 1'b0;
        else        pend_garp_q <= pend_garp_d;
    end
`endif

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = 1'b0;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx; builds each expected burst from the ARP
// field layout and an MSB-first CRC-32 formulation.
module tb_arp_tx;

    logic        aclk = 1'b0;
    logic        areset;
    logic        arp_data_valid;
    logic [47:0] rq_mac_addr, mac_s_addr;
    logic [31:0] rq_ip_addr, ip_s_addr;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en, gmii_tx_er, busy, tx_done;
`ifdef ARP_TX_GRATUITOUS_EN
    logic        garp_req;
`endif

    logic        crc_clr, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    always #4 aclk = ~aclk;

    arp_tx u_dut (
        .aclk           (aclk),
        .areset         (areset),
`ifdef ARP_TX_GRATUITOUS_EN
        .garp_req       (garp_req),
`endif
        .arp_data_valid (arp_data_valid),
        .rq_mac_addr    (rq_mac_addr),
        .rq_ip_addr     (rq_ip_addr),
        .mac_s_addr     (mac_s_addr),
        .ip_s_addr      (ip_s_addr),
        .gmii_txd       (gmii_txd),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_tx_er     (gmii_tx_er),
        .busy           (busy),
        .tx_done        (tx_done)
    );

    crc32_d8 u_crc (
        .clk    (aclk),
        .rst    (areset),
        .clear  (crc_clr),
        .enable (crc_en),
        .data   (crc_data),
        .crc    (crc_out)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Reflected CRC-32 expressed as a normal MSB-first CRC on bit-reversed data
    function automatic logic [31:0] ref_fcs(input int first, input int last);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = first; k <= last; k++) begin
            c = c ^ {rev8(exp_q[k]), 24'h0};
            for (int b = 0; b < 8; b++)
                c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        return ~rev32(c);
    endfunction

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_expected(input bit garp, input logic [47:0] rmac, input logic [31:0] rip,
                                  input logic [47:0] lmac, input logic [31:0] lip);
        logic [31:0] f;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(garp ? 64'hFFFF_FFFF_FFFF : {16'h0, rmac}, 6);
        push_be({16'h0, lmac}, 6);
        push_be(64'h0806, 2);
        push_be(64'h0001, 2);
        push_be(64'h0800, 2);
        push_be(64'h06, 1);
        push_be(64'h04, 1);
        push_be(garp ? 64'h0001 : 64'h0002, 2);
        push_be({16'h0, lmac}, 6);
        push_be({32'h0, lip}, 4);
        push_be(garp ? 64'h0 : {16'h0, rmac}, 6);
        push_be({32'h0, garp ? lip : rip}, 4);
        for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
        f = ref_fcs(8, 67);
        for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
    endtask

    task automatic pulse_req(input logic [47:0] m, input logic [31:0] ip);
        @(negedge aclk);
        arp_data_valid = 1'b1;
        rq_mac_addr    = m;
        rq_ip_addr     = ip;
        @(negedge aclk);
        arp_data_valid = 1'b0;
    endtask

    // Waits (bounded) for tx_en, then checks all 72 burst cycles; returns on the tx_done cycle
    task automatic check_frame(input string name, input int max_wait);
        int waited;
        waited = 0;
        while (gmii_tx_en !== 1'b1 && waited < max_wait) begin
            @(negedge aclk);
            waited++;
        end
        if (gmii_tx_en !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s start: tx_en=%b after %0d cycles, required 1", name, gmii_tx_en, max_wait);
            return;
        end
        for (int i = 0; i < 72; i++) begin
            n_checks++;
            if (gmii_txd !== exp_q[i] || gmii_tx_en !== 1'b1 || gmii_tx_er !== 1'b0 ||
                tx_done !== (i == 71)) begin
                n_fail++;
                $display("FAIL %s byte %0d: txd=%h en=%b er=%b done=%b, required txd=%h en=1 er=0 done=%b",
                         name, i, gmii_txd, gmii_tx_en, gmii_tx_er, tx_done, exp_q[i], (i == 71));
            end
            if (i < 71) @(negedge aclk);
        end
    endtask

    // Checks n idle cycles following the current sample
    task automatic check_gap(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge aclk);
            n_checks++;
            if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) begin
                n_fail++;
                $display("FAIL %s gap cycle %0d: en=%b txd=%h, required en=0 txd=00", name, k, gmii_tx_en, gmii_txd);
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        arp_data_valid = 1'b0;
        rq_mac_addr = 48'h0;
        rq_ip_addr = 32'h0;
        mac_s_addr = 48'h0200_0000_0001;
        ip_s_addr = 32'hC0A8_0164;
        crc_clr = 1'b0;
        crc_en = 1'b0;
        crc_data = 8'h00;
`ifdef ARP_TX_GRATUITOUS_EN
        garp_req = 1'b0;
`endif
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            n_checks++;
            if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || busy !== 1'b0 || tx_done !== 1'b0 || gmii_tx_er !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: en=%b txd=%h busy=%b done=%b er=%b, required all 0",
                         k, gmii_tx_en, gmii_txd, busy, tx_done, gmii_tx_er);
            end
        end
    endtask

    task automatic test_crc();
        logic [7:0] msg [9];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        @(negedge aclk);
        crc_clr = 1'b1;
        @(negedge aclk);
        crc_clr = 1'b0;
        crc_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            crc_data = msg[i];
            @(negedge aclk);
        end
        crc_en = 1'b0;
        n_checks++;
        if (~crc_out !== 32'hCBF43926) begin
            n_fail++;
            $display("FAIL crc_check: got %h, required CBF43926", ~crc_out);
        end
    endtask

    task automatic test_fixed_frame();
        logic [47:0] m;
        logic [31:0] ip;
        m = 48'h0011_2233_4455;
        ip = 32'hC0A8_010A;
        mac_s_addr = 48'h0200_0000_0001;
        ip_s_addr = 32'hC0A8_0164;
        build_expected(1'b0, m, ip, mac_s_addr, ip_s_addr);
        pulse_req(m, ip);
        // Inputs change right after acceptance; the frame must not follow them
        rq_mac_addr = 48'hDEAD_BEEF_0000;
        rq_ip_addr = 32'h0A0B_0C0D;
        mac_s_addr = 48'h0A0A_0A0A_0A0A;
        ip_s_addr = 32'h0101_0101;
        n_checks++;
        if (busy !== 1'b1 || gmii_tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_cycle: busy=%b en=%b, required busy=1 en=0", busy, gmii_tx_en);
        end
        @(negedge aclk);
        n_checks++;
        if (gmii_tx_en !== 1'b1 || gmii_txd !== 8'h55) begin
            n_fail++;
            $display("FAIL latency: en=%b txd=%h, required en=1 txd=55", gmii_tx_en, gmii_txd);
        end
        check_frame("fixed", 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge aclk);
            n_checks++;
            if (busy !== (k < 12) || gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ifg_busy cycle %0d: busy=%b en=%b txd=%h done=%b, required busy=%b en=0 txd=00 done=0",
                         k, busy, gmii_tx_en, gmii_txd, tx_done, (k < 12));
            end
        end
        mac_s_addr = 48'h0200_0000_0001;
        ip_s_addr = 32'hC0A8_0164;
    endtask

    task automatic test_random_frames();
        logic [47:0] m;
        logic [31:0] ip;
        for (int it = 0; it < 4; it++) begin
            mac_s_addr = {16'($urandom), $urandom};
            ip_s_addr = $urandom;
            m = {16'($urandom), $urandom};
            ip = $urandom;
            repeat ($urandom_range(0, 5)) @(negedge aclk);
            build_expected(1'b0, m, ip, mac_s_addr, ip_s_addr);
            pulse_req(m, ip);
            check_frame($sformatf("random%0d", it), 4);
            repeat (14) @(negedge aclk);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] ma, mb, mc, md;
        logic [31:0] ia, ib, ic, id;
        int seen;
        ma = {16'($urandom), $urandom}; ia = $urandom;
        mb = {16'($urandom), $urandom}; ib = $urandom;
        mc = {16'($urandom), $urandom}; ic = $urandom;
        md = {16'($urandom), $urandom}; id = $urandom;
        build_expected(1'b0, ma, ia, mac_s_addr, ip_s_addr);
        pulse_req(ma, ia);
        @(negedge aclk);
        fork
            check_frame("b2b_first", 0);
            begin
                repeat (5) @(negedge aclk);
                arp_data_valid = 1'b1; rq_mac_addr = mb; rq_ip_addr = ib;
                @(negedge aclk);
                arp_data_valid = 1'b0;
                repeat (4) @(negedge aclk);
                arp_data_valid = 1'b1; rq_mac_addr = mc; rq_ip_addr = ic;
                @(negedge aclk);
                arp_data_valid = 1'b0;
                repeat (4) @(negedge aclk);
                arp_data_valid = 1'b1; rq_mac_addr = md; rq_ip_addr = id;
                @(negedge aclk);
                arp_data_valid = 1'b0;
            end
        join
        check_gap("b2b", 12);
        @(negedge aclk);
        build_expected(1'b0, mb, ib, mac_s_addr, ip_s_addr);
        check_frame("b2b_second", 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (gmii_tx_en !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_third_dropped: tx_en cycles=%0d busy=%b, required 0 and 0", seen, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [47:0] m;
        logic [31:0] ip;
        int seen;
        m = {16'($urandom), $urandom};
        ip = $urandom;
        pulse_req(m, ip);
        @(negedge aclk);
        repeat (38) @(negedge aclk);   // burst index 38 = frame byte 30
        areset = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || busy !== 1'b0 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: en=%b txd=%h busy=%b done=%b, required all 0", gmii_tx_en, gmii_txd, busy, tx_done);
        end
        areset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (gmii_tx_en !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_resume: active cycles=%0d, required 0", seen);
        end
        m = {16'($urandom), $urandom};
        ip = $urandom;
        build_expected(1'b0, m, ip, mac_s_addr, ip_s_addr);
        pulse_req(m, ip);
        check_frame("after_reset", 4);
        repeat (14) @(negedge aclk);
    endtask

`ifdef ARP_TX_GRATUITOUS_EN
    task automatic test_garp();
        logic [47:0] m;
        logic [31:0] ip;
        m = {16'($urandom), $urandom};
        ip = $urandom;
        build_expected(1'b0, m, ip, mac_s_addr, ip_s_addr);
        @(negedge aclk);
        arp_data_valid = 1'b1; garp_req = 1'b1; rq_mac_addr = m; rq_ip_addr = ip;
        @(negedge aclk);
        arp_data_valid = 1'b0; garp_req = 1'b0;
        @(negedge aclk);
        check_frame("garp_reply_first", 0);
        check_gap("garp", 12);
        @(negedge aclk);
        build_expected(1'b1, m, ip, mac_s_addr, ip_s_addr);
        check_frame("garp_broadcast", 0);
        repeat (14) @(negedge aclk);
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_crc();
        test_fixed_frame();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef ARP_TX_GRATUITOUS_EN
        test_garp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arp_tx.md
ARP_TX -- requirements
Module: arp_tx

Interface
REQ-001 SHALL have ports: aclk  in  1  sole clock (GMII TX clock, 125 MHz); all logic rising-edge.
REQ-002 SHALL have port: areset  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port: arp_data_valid  in  1  one-cycle pulse, a valid ARP request for us was received.
REQ-004 SHALL have port: rq_mac_addr  in  48  requester MAC, qualified by arp_data_valid.
REQ-005 SHALL have port: rq_ip_addr  in  32  requester IP, qualified by arp_data_valid.
REQ-006 SHALL have port: mac_s_addr  in  48  local MAC; ip_s_addr  in  32  local IP (quasi-static).
REQ-007 SHALL have ports: gmii_txd  out  8; gmii_tx_en  out  1; gmii_tx_er  out  1.
REQ-008 SHALL have ports: busy  out  1  frame or IFG in progress; tx_done  out  1  one-cycle pulse on last FCS byte.

Function
REQ-009 SHALL emit, per accepted request, exactly 72 tx_en cycles: 7x 0x55, 0xD5, 60-byte frame, 4-byte FCS.
REQ-010 Frame bytes SHALL be: dst=rq_mac, src=mac_s_addr, type 0x0806, HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04, OPER 0x0002, SHA=mac_s_addr, SPA=ip_s_addr, THA=rq_mac, TPA=rq_ip, then 18 bytes 0x00; multi-byte fields MSB first.
REQ-011 FCS SHALL be CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over the 60 frame bytes only, sent least-significant byte first.
REQ-012 FSM states SHALL be IDLE, PREAMBLE (8 cycles incl. SFD), FRAME (42), PAD (18), FCS (4), IFG (12); byte counter reset on each state entry.
REQ-013 Request sampled in IDLE at edge N SHALL produce the first 0x55 with tx_en=1 at edge N+1 (latency 1 cycle).
REQ-014 rq_mac_addr/rq_ip_addr/mac_s_addr/ip_s_addr SHALL be latched on acceptance; later input changes do not affect the frame.
REQ-015 During IFG gmii_tx_en=0, gmii_txd=0x00; busy=1 from acceptance through last IFG cycle.
REQ-016 A request arriving while busy SHALL be held in a single-entry pending slot and started at the IFG->IDLE transition; further requests while the slot is full SHALL be dropped (newest not stored).
REQ-017 gmii_tx_er SHALL be constant 0.
REQ-018 Outputs SHALL be registered; gmii_txd=0x00 whenever gmii_tx_en=0.

Reset
REQ-019 On areset: state IDLE, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, busy=0, tx_done=0, pending slot cleared, CRC=0xFFFFFFFF.
REQ-020 Reset mid-frame SHALL drop tx_en on the next edge; no partial FCS emitted; no resumption.

Configuration
REQ-021 Macro ARP_TX_GRATUITOUS_EN defined: adds input garp_req (1-cycle pulse) sending a gratuitous ARP: dst FF:FF:FF:FF:FF:FF, OPER 0x0001, THA 0, TPA=ip_s_addr; same timing/pending rules, own pending slot.
REQ-022 With both requests in the same IDLE cycle, reply SHALL go first, gratuitous pended.
REQ-023 Macro undefined: no garp_req port, no related logic; behaviour per REQ-009..020.

Structure
REQ-024 Shared package eth_pkg SHALL hold: ETH_TYPE_ARP, ETH_TYPE_IP, ARP_HTYPE_ETH, ARP_OPER_REQ/REPLY, PREAMBLE_BYTE, SFD_BYTE, MIN_FRAME_LEN=60, IFG_LEN=12, CRC32_POLY/INIT, FSM state enum.
REQ-025 CRC SHALL be a sub-module crc32_d8 (8-bit-per-cycle, clear/enable inputs), reusable by the receive side.

Verification
REQ-026 Reset, idle 20 cycles -> tx_en=0, txd=0x00, busy=0 throughout.
REQ-027 arp_data_valid, rq_mac=00:11:22:33:44:55, rq_ip=192.168.1.10, local 02:00:00:00:00:01/192.168.1.100 -> 72-cycle burst, bytes per REQ-010, FCS matches golden model, tx_done on cycle 72, busy low 12 cycles later.
REQ-028 crc32_d8 fed ASCII "123456789" -> complemented result 0xCBF43926.
REQ-029 Three requests at cycles 5, 10, 15 of a frame -> two frames back-to-back, exactly 12 idle cycles between, third dropped.
REQ-030 areset at frame byte 30 -> tx_en=0 next edge; next request produces full correct frame.
REQ-031 ARP_TX_GRATUITOUS_EN, garp_req and arp_data_valid same cycle -> reply frame, 12-cycle IFG, then broadcast frame with OPER 0x0001.
